// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-based arbiter sharing one FIFO write
// port among NUM_REQ producers. An owner keeps the grant for up to BURST_LEN
// accepted beats (or until it drops its request), then the grant rotates.
// FIFO full stalls the owner without dropping data.
//
// Optional feature (macro FIFO_ARB_STATS_EN): adds saturating 16-bit
// beat_cnt_o (accepted beats) and stall_cnt_o (owner blocked by full).
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous reset, active low
//   req_i          per-requester write request, held with data until acked
//   data_i         packed write data, requester k at [k*WIDTH +: WIDTH]
//   gnt_o          registered one-hot owner, zero when idle
//   ack_o          beat accept = gnt_o & req_i & ~fifo_full_i
//   fifo_wr_en_o   FIFO write enable = |ack_o
//   fifo_wdata_o   owner's data slice, zero when idle
//   fifo_full_i    FIFO full flag
//   beat_cnt_o     (stats only) accepted beat count
//   stall_cnt_o    (stats only) full-stall cycle count

// Per-requester lane: accept and data masking for one producer.
module fifo_wr_arbiter_lane #(
  parameter int WIDTH = 8
) (
  input  logic             gnt,
  input  logic             req,
  input  logic             full,
  input  logic [WIDTH-1:0] data,
  output logic             ack,
  output logic [WIDTH-1:0] data_q
);
  assign ack    = gnt & req & ~full;
  assign data_q = gnt ? data : '0;
endmodule

module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4,
  parameter int IDX_WIDTH = 2,
  parameter int CNT_WIDTH = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*WIDTH-1:0] data_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [NUM_REQ-1:0]       ack_o,
  output logic                     fifo_wr_en_o,
  output logic [WIDTH-1:0]         fifo_wdata_o,
  input  logic                     fifo_full_i
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [15:0]              beat_cnt_o,
  output logic [15:0]              stall_cnt_o
`endif
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t                          state_q, state_d;
  logic [NUM_REQ-1:0]              gnt_q, gnt_d;
  logic [IDX_WIDTH-1:0]            owner_q, owner_d;
  logic [IDX_WIDTH-1:0]            rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0]            beat_q, beat_d;

  logic [NUM_REQ-1:0][WIDTH-1:0]   lane_data;
  logic                            accept, owner_req, last_beat;
  logic [IDX_WIDTH-1:0]            nxt_idx, pick_start, pick_idx;
  logic                            pick_vld;

  // First set bit of r at or above start, wrapping; returns {valid, index}.
  function automatic logic [IDX_WIDTH:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_WIDTH-1:0] start);
    logic [IDX_WIDTH-1:0] sel;
    logic                 found;
    int                   j;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(start) + i) % NUM_REQ;
      if (!found && r[j]) begin
        found = 1'b1;
        sel   = IDX_WIDTH'(j);
      end
    end
    return {found, sel};
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    fifo_wr_arbiter_lane #(.WIDTH(WIDTH)) u_lane (
      .gnt    (gnt_q[g]),
      .req    (req_i[g]),
      .full   (fifo_full_i),
      .data   (data_i[g*WIDTH +: WIDTH]),
      .ack    (ack_o[g]),
      .data_q (lane_data[g])
    );
  end

  // Grant is one-hot (or zero), so OR-ing the masked lanes is the mux.
  always_comb begin
    fifo_wdata_o = '0;
    for (int i = 0; i < NUM_REQ; i++) fifo_wdata_o = fifo_wdata_o | lane_data[i];
  end

  assign gnt_o        = gnt_q;
  assign accept       = |ack_o;
  assign fifo_wr_en_o = accept;
  assign owner_req    = req_i[owner_q];
  assign last_beat    = (int'(beat_q) + 1) == BURST_LEN;
  assign nxt_idx      = IDX_WIDTH'((int'(owner_q) + 1) % NUM_REQ);

  // On release the search starts just past the old owner, so it ranks last
  // but is still re-granted when it is the only requester.
  assign pick_start             = (state_q == IDLE) ? rr_ptr_q : nxt_idx;
  assign {pick_vld, pick_idx}   = rr_pick(req_i, pick_start);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    beat_d   = beat_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = BURST;
          gnt_d   = NUM_REQ'(1) << pick_idx;
          owner_d = pick_idx;
          beat_d  = '0;
        end
      end
      BURST: begin
        if (accept) beat_d = beat_q + 1'b1;
        if ((accept && last_beat) || !owner_req) begin
          rr_ptr_d = nxt_idx;
          beat_d   = '0;
          if (pick_vld) begin
            gnt_d   = NUM_REQ'(1) << pick_idx;
            owner_d = pick_idx;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] beat_cnt_q, stall_cnt_q;
  logic        stall;

  assign stall = (|gnt_q) & owner_req & fifo_full_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (accept && beat_cnt_q != 16'hFFFF)  beat_cnt_q  <= beat_cnt_q + 16'd1;
      if (stall && stall_cnt_q != 16'hFFFF)  stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign beat_cnt_o  = beat_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int BL = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N-1:0]        req = '0;
  logic [N-1:0][W-1:0] dat = '0;
  logic                full_drv = 1'b0;
  logic                full;
  logic [N-1:0]        gnt, ack;
  logic                wen;
  logic [W-1:0]        wd;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0]         bc, sc;
`endif

  int errors = 0;
  int checks = 0;

  // Behavioural depth-16 FIFO used by the full-FIFO scenario.
  logic       use_fifo = 1'b0;
  int         fifo_cnt = 0;
  logic       wr_err   = 1'b0;
  logic [W-1:0] fifo_q[$];

  assign full = use_fifo ? (fifo_cnt >= 16) : full_drv;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .BURST_LEN(BL), .IDX_WIDTH(2), .CNT_WIDTH(3)) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .req_i        (req),
    .data_i       (dat),
    .gnt_o        (gnt),
    .ack_o        (ack),
    .fifo_wr_en_o (wen),
    .fifo_wdata_o (wd),
    .fifo_full_i  (full)
`ifdef FIFO_ARB_STATS_EN
    ,
    .beat_cnt_o   (bc),
    .stall_cnt_o  (sc)
`endif
  );

  logic [N-1:0] s_gnt, s_ack;
  logic         s_wen;
  logic [W-1:0] s_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after a rising edge with inputs set; samples outputs at the
  // falling edge and returns 1ns after the next rising edge.
  task automatic tick();
    @(negedge clk);
    s_gnt = gnt; s_ack = ack; s_wen = wen; s_wd = wd;
    if (use_fifo && wen && fifo_cnt >= 16) wr_err = 1'b1;
    @(posedge clk); #1;
    if (use_fifo && s_wen) begin
      fifo_q.push_back(s_wd);
      fifo_cnt++;
    end
  endtask

  task automatic do_reset();
    req = '0; full_drv = 1'b0; use_fifo = 1'b0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_wen", 32'(wen), 0);
    chk("rst_wdata", 32'(wd), 0);
    rst_n = 1'b1;
  endtask

  function automatic int pick(input logic [N-1:0] r, input int start);
    for (int i = 0; i < N; i++) if (r[(start + i) % N]) return (start + i) % N;
    return -1;
  endfunction

  typedef struct {
    logic [N-1:0] req;
    logic         full;
    logic [N-1:0] gnt;
    logic [N-1:0] ack;
    logic [W-1:0] wd;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // ---- 1: idle after reset ----
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_gnt", 32'(s_gnt), 0);
      chk("idle_wen", 32'(s_wen), 0);
    end

    // ---- table: rotation, stall, owner drop, sole re-grant ----
    tbl[0]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 8'h00};
    tbl[1]  = '{4'b0101, 1'b0, 4'b0000, 4'b0000, 8'h00};
    tbl[2]  = '{4'b0101, 1'b0, 4'b0001, 4'b0001, 8'hA0};
    tbl[3]  = '{4'b0101, 1'b1, 4'b0001, 4'b0000, 8'hA0};
    tbl[4]  = '{4'b0101, 1'b0, 4'b0001, 4'b0001, 8'hA0};
    tbl[5]  = '{4'b0100, 1'b0, 4'b0001, 4'b0000, 8'hA0};
    tbl[6]  = '{4'b0100, 1'b0, 4'b0100, 4'b0100, 8'hA2};
    tbl[7]  = '{4'b0100, 1'b0, 4'b0100, 4'b0100, 8'hA2};
    tbl[8]  = '{4'b0100, 1'b0, 4'b0100, 4'b0100, 8'hA2};
    tbl[9]  = '{4'b0100, 1'b0, 4'b0100, 4'b0100, 8'hA2};
    tbl[10] = '{4'b0000, 1'b0, 4'b0100, 4'b0000, 8'hA2};
    tbl[11] = '{4'b1001, 1'b0, 4'b0000, 4'b0000, 8'h00};
    tbl[12] = '{4'b1001, 1'b0, 4'b1000, 4'b1000, 8'hA3};
    tbl[13] = '{4'b1001, 1'b0, 4'b1000, 4'b1000, 8'hA3};
    do_reset();
    for (int k = 0; k < N; k++) dat[k] = W'(8'hA0 + k);
    for (int i = 0; i < 14; i++) begin
      req = tbl[i].req; full_drv = tbl[i].full;
      tick();
      chk($sformatf("tbl%0d_gnt", i), 32'(s_gnt), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_ack", i), 32'(s_ack), 32'(tbl[i].ack));
      chk($sformatf("tbl%0d_wen", i), 32'(s_wen), 32'(|tbl[i].ack));
      chk($sformatf("tbl%0d_wd", i), 32'(s_wd), 32'(tbl[i].wd));
    end

    // ---- 2: sole requester, continuous across burst boundaries ----
    do_reset();
    dat[1] = 8'h10; req = 4'b0010;
    tick();
    chk("solo_latency_gnt", 32'(s_gnt), 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("solo_gnt", 32'(s_gnt), 32'(4'b0010));
      chk("solo_wen", 32'(s_wen), 1);
      chk("solo_wd", 32'(s_wd), 32'(8'h10 + i));
      if (s_ack[1]) dat[1] = dat[1] + 8'd1;
    end

    // ---- 3: all request into a depth-16 FIFO, no reads ----
    do_reset();
    fifo_q.delete(); fifo_cnt = 0; wr_err = 1'b0; use_fifo = 1'b1;
    for (int k = 0; k < N; k++) dat[k] = W'(k * 16);
    req = 4'b1111;
    tick();
    chk("fifo_latency_gnt", 32'(s_gnt), 0);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("fifo_wen", 32'(s_wen), 1);
      chk("fifo_gnt", 32'(s_gnt), 32'(4'b0001 << (i / 4)));
      chk("fifo_wd", 32'(s_wd), 32'((i / 4) * 16 + (i % 4)));
      for (int k = 0; k < N; k++) if (s_ack[k]) dat[k] = dat[k] + 8'd1;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fifo_full_wen", 32'(s_wen), 0);
      chk("fifo_full_gnt", 32'(s_gnt), 32'(4'b0001));
    end
    chk("fifo_count", 32'(fifo_cnt), 16);
    chk("fifo_wr_error", 32'(wr_err), 0);
    use_fifo = 1'b0;

    // ---- 4: full mid-burst holds the grant, then completes and rotates ----
    do_reset();
    req = 4'b0011;
    tick();
    chk("stall_latency_gnt", 32'(s_gnt), 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_pre_ack", 32'(s_ack), 32'(4'b0001));
    end
    full_drv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_ack", 32'(s_ack), 0);
      chk("stall_gnt", 32'(s_gnt), 32'(4'b0001));
    end
    full_drv = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_post_ack", 32'(s_ack), 32'(4'b0001));
    end
    tick();
    chk("stall_rotate_gnt", 32'(s_gnt), 32'(4'b0010));
`ifdef FIFO_ARB_STATS_EN
    chk("stall_stat_cnt", 32'(sc), 3);
`endif

    // ---- 6: asynchronous reset mid-burst ----
    do_reset();
    req = 4'b0100;
    tick();
    tick();
    chk("areset_pre_gnt", 32'(s_gnt), 32'(4'b0100));
    #2 rst_n = 1'b0;
    #1;
    chk("areset_gnt", 32'(gnt), 0);
    chk("areset_wen", 32'(wen), 0);
    chk("areset_wd", 32'(wd), 0);
`ifdef FIFO_ARB_STATS_EN
    chk("areset_beats", 32'(bc), 0);
    chk("areset_stalls", 32'(sc), 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1; req = 4'b1111;
    tick();
    chk("areset_idle_gnt", 32'(s_gnt), 0);
    tick();
    chk("areset_restart_gnt", 32'(s_gnt), 32'(4'b0001));

    // ---- randomized traffic against a rule-level reference model ----
    begin
      int           own, cnt, ptr, m_beats, m_stalls;
      logic [N-1:0] pend, e_gnt, e_ack;
      logic [W-1:0] e_wd;
      do_reset();
      own = -1; cnt = 0; ptr = 0; m_beats = 0; m_stalls = 0; pend = '0;
      for (int c = 0; c < 400; c++) begin
        for (int k = 0; k < N; k++)
          if (!pend[k] && $urandom_range(0, 2) == 0) begin
            pend[k] = 1'b1;
            dat[k]  = W'($urandom);
          end
        req = pend;
        full_drv = ($urandom_range(0, 4) == 0);
        e_gnt = (own >= 0) ? (N'(1) << own) : '0;
        e_ack = (own >= 0 && req[own] && !full_drv) ? e_gnt : '0;
        e_wd  = (own >= 0) ? dat[own] : '0;
        tick();
        chk("rnd_gnt", 32'(s_gnt), 32'(e_gnt));
        chk("rnd_ack", 32'(s_ack), 32'(e_ack));
        chk("rnd_wen", 32'(s_wen), 32'(|e_ack));
        chk("rnd_wd", 32'(s_wd), 32'(e_wd));
        if (e_ack != 0) m_beats++;
        if (own >= 0 && req[own] && full_drv) m_stalls++;
        // model: grant/rotate rules applied at the edge
        if (own < 0) begin
          own = pick(req, ptr);
          cnt = 0;
        end else begin
          if (e_ack != 0) cnt++;
          if ((e_ack != 0 && cnt == BL) || !req[own]) begin
            ptr = (own + 1) % N;
            own = pick(req, ptr);
            cnt = 0;
          end
        end
        pend = pend & ~e_ack;
      end
`ifdef FIFO_ARB_STATS_EN
      chk("rnd_stat_beats", 32'(bc), 32'(m_beats));
      chk("rnd_stat_stalls", 32'(sc), 32'(m_stalls));
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin, burst-based write arbiter that shares the single write port of the team's synchronous FIFO among NUM_REQ producers.
- Sits between the producers and the FIFO write interface (wr_en / wdata / full).
- Grants one owner at a time for up to BURST_LEN accepted beats, then rotates.
- Stalls cleanly on FIFO full without dropping data.

Parameters:
NUM_REQ, 4, number of requesters
WIDTH, 8, data width; must match the FIFO WIDTH
BURST_LEN, 4, maximum beats per grant before forced rotation
IDX_WIDTH, 2, width of requester index (log2 NUM_REQ)
CNT_WIDTH, 3, width of beat counter; must hold 0..BURST_LEN

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-low
req_i  in  NUM_REQ  per-requester write request; held with data until acked
data_i  in  NUM_REQ*WIDTH  packed write data; requester k uses bits [k*WIDTH +: WIDTH]
gnt_o  out  NUM_REQ  registered one-hot current owner; all-zero when idle
ack_o  out  NUM_REQ  combinational beat accept = gnt_o & req_i & ~fifo_full_i
fifo_wr_en_o  out  1  to FIFO wr_en = |ack_o
fifo_wdata_o  out  WIDTH  to FIFO wdata = owner's data_i slice; 0 when idle
fifo_full_i  in  1  from FIFO full

Behaviour:
- Reset (rst_i low, asynchronous):
  - Takes effect immediately: state IDLE, gnt_o=0, owner=0, rr_ptr=0, beat_cnt=0.
  - Consequently ack_o=0, fifo_wr_en_o=0, fifo_wdata_o=0.
- Beat transfer:
  - A beat transfers on a rising edge where ack_o[k]=1.
  - Requester k must hold data_i slice and req_i[k] stable until it sees ack_o[k]=1.
- FSM states: IDLE, BURST.
- IDLE:
  - If |req_i, select the first set bit of req_i searching from rr_ptr upward with wrap.
  - Register gnt_o=onehot(sel) and owner=sel; clear beat_cnt; go to BURST.
  - Grant latency is 1 cycle from request to gnt_o.
- BURST:
  - Each accepted beat increments beat_cnt.
  - fifo_full_i=1: ack_o=0, beat_cnt held, grant held indefinitely (no timeout).
- Release condition, evaluated at the edge:
  - (accept and beat_cnt+1==BURST_LEN), or
  - (req_i[owner]=0).
- On release:
  - rr_ptr := owner+1 mod NUM_REQ.
  - Re-arbitrate the same edge over the current req_i, searching from owner+1 with wrap, so the old owner has lowest priority.
  - If a requester is found, grant it directly with beat_cnt=0 (zero-bubble handover). Otherwise go to IDLE with gnt_o=0.
- A sole active requester is re-granted back to back: continuous writes, no gap.
- Requests are never dropped. The arbiter never issues fifo_wr_en_o while fifo_full_i=1, so FIFO wr_error never asserts.
- Requests arriving mid-burst wait for the release point.

Optional Feature:
FIFO_ARB_STATS_EN
- Defined: adds output ports beat_cnt_o[15:0] and stall_cnt_o[15:0].
  - beat_cnt_o counts accepted beats.
  - stall_cnt_o counts cycles with gnt_o!=0 & req_i[owner] & fifo_full_i.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
1. rst_i low, req_i=4'b0000, then release -> gnt_o=0, fifo_wr_en_o=0 for 10 cycles.
2. req_i=4'b0010 continuous, data 0x10,0x11,... advancing on ack -> gnt_o=4'b0010 one cycle later; 8 consecutive fifo_wr_en_o pulses with wdata 0x10..0x17, no gap at the BURST_LEN handover.
3. req_i=4'b1111 into a real depth-16 FIFO, no reads -> bursts of 4 beats in grant order 0,1,2,3. After 16 writes full_o=1: fifo_wr_en_o=0, gnt_o stays 4'b0001, FIFO wr_error_o never asserts.
4. Owner 0 mid-burst at beat 2, fifo_full_i=1 for 3 cycles -> ack_o=0 for 3 cycles, grant held, beats 3-4 complete afterwards, then rotate to requester 1.
5. req_i=4'b0101; requester 0 drops req after 2 beats -> gnt_o=4'b0100 on the next edge; then requester 2 keeps requesting alone -> re-granted to 2.
6. rst_i asserted asynchronously mid-burst (between edges) -> gnt_o, fifo_wr_en_o and stats counters go 0 immediately; after release, arbitration restarts at index 0.
